// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract sequencer.
// Drives one shared, externally instantiated full adder one bit per clock,
// LSB first. Subtraction is a + ~b + 1, so the carry is preloaded with 'sub'.
// Handshake: start is a request that is taken only while the block is idle
// (busy low); once taken the op runs for exactly WIDTH cycles and then
// announces completion with a single-cycle done pulse. Requests seen while
// busy are dropped, never queued.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic [1:0]       fa_in,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] r_sh_q, r_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;

    // State and datapath registers; synchronous active-low reset wins over everything.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            r_sh_q      <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            r_sh_q      <= r_sh_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    // Next-state and datapath update: latch on accept, shift one bit per RUN cycle.
    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        r_sh_d      = r_sh_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                r_sh_d  = {fa_sum, r_sh_q[WIDTH-1:1]};
                carry_d = fa_cout;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // carry_q is the carry into the MSB; fa_cout is the carry out of it.
                    state_d     = DONE;
                    result_d    = {fa_sum, r_sh_q[WIDTH-1:1]};
                    carry_out_d = fa_cout;
                    overflow_d  = carry_q ^ fa_cout;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: adder is only driven while RUN; results come straight from registers.
    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        fa_in     = 2'b00;
        fa_cin    = 1'b0;
        result    = result_q;
        carry_out = carry_out_q;
        overflow  = overflow_q;
        if (state_q == RUN) begin
            fa_in  = {b_sh_q[0], a_sh_q[0]};
            fa_cin = carry_q;
        end
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial add/subtract sequencer that time-shares one external fullAdder instance across WIDTH-bit operands, one bit per clock, LSB first.
- Latches operands on a start handshake, drives the adder's in/cin each cycle, and captures its sum/cout into a result shift register.
- Reports result, carry and signed overflow with a one-cycle done pulse.
- Sits between the operand/control logic and the shared adder, which is instantiated one level up and wired to the fa_* ports.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2 to 32.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset_n  input  1  synchronous, active-low reset; sampled on posedge clk.
- start  input  1  request; accepted only in IDLE.
- sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse in DONE.
- result  output  WIDTH  registered sum/difference.
- carry_out  output  1  final adder cout; for sub, 1 = no borrow.
- overflow  output  1  two's-complement overflow of the operation.
- fa_in  output  2  to adder in[1:0]; {b bit, a bit}.
- fa_cin  output  1  to adder cin.
- fa_sum  input  1  from adder sum.
- fa_cout  input  1  from adder cout.

Behaviour:
- States: IDLE, RUN, DONE. Registers: a_sh, b_sh (WIDTH), r_sh (WIDTH), carry (1), cnt (clog2 WIDTH), state.
- Reset (reset_n low at posedge):
  - state=IDLE; a_sh, b_sh, r_sh, carry and cnt cleared.
  - result=0, carry_out=0, overflow=0.
  - busy=0, done=0, fa_in=0, fa_cin=0.
  - Reset takes priority over every other event and aborts any op in flight; no done is issued for the aborted op.
- IDLE, start=1 at posedge:
  - a_sh<=a; b_sh<=sub ? ~b : b; carry<=sub; cnt<=0; state<=RUN.
  - start=0: remain in IDLE.
- RUN (combinational outputs): fa_in={b_sh[0],a_sh[0]}, fa_cin=carry.
- RUN (each posedge):
  - r_sh<={fa_sum, r_sh[WIDTH-1:1]}; carry<=fa_cout.
  - a_sh, b_sh shift right by 1 (zero fill); cnt<=cnt+1.
- RUN exit, at the posedge where cnt==WIDTH-1:
  - state<=DONE.
  - result<={fa_sum, r_sh[WIDTH-1:1]}; carry_out<=fa_cout.
  - overflow<=carry ^ fa_cout (carry into MSB xor carry out of MSB).
- RUN length: exactly WIDTH cycles. The adder is combinational; the clock period must exceed its propagation delay.
- DONE: done=1 for exactly one cycle, then state<=IDLE unconditionally.
- fa_in and fa_cin are 0 in IDLE and DONE.
- busy: high in RUN and DONE, low in IDLE.
- start in RUN or DONE is ignored, not queued.
- Changes on a, b or sub after acceptance do not affect the op in flight.
- result, carry_out and overflow hold their values from the end of RUN until the next completed op or reset; they never change during RUN.
- Latency: start sampled at edge E0 → done high in the cycle after edge E(WIDTH). Minimum issue interval is WIDTH+2 cycles, because one IDLE cycle is required between ops.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with start=1 → every output 0, busy=0, no done.
- Add, WIDTH=8: a=0x5A, b=0x3C, sub=0, start at E0.
  - During RUN cycle i, fa_in must equal {b[i],a[i]}.
  - done high only after E8; result=0x96, carry_out=0, overflow=1.
- Add wrap: a=0xFF, b=0x01 → result=0x00, carry_out=1, overflow=0. Back-to-back start asserted during DONE is ignored; start in the next IDLE cycle is accepted.
- Subtract:
  - 0x10-0x20 → result=0xF0, carry_out=0, overflow=0.
  - 0x80-0x01 → result=0x7F, carry_out=1, overflow=1.
  - First RUN cycle of each has fa_cin=1.
- Interference: start pulses and random a/b/sub changes throughout RUN for a=0x33+b=0x44 → single done, result=0x77, and result stays at its prior value until the cycle after E8.
- Mid-op reset: reset_n=0 at edge E4 of an op → IDLE at E4, busy=0 next cycle, no done ever, result=0. A new start is then accepted normally.
